// File: rtl/decoder_pkg.sv
// Shared constants, FSM state encoding and the code-to-one-hot decode helper
// for the decoder_strobe block.
package decoder_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 2 ** CODE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [OUT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Synchronous FIFO with occupancy count; rst and flush both empty it at the edge.
// DEPTH must be a power of two so the pointers wrap naturally.
module code_fifo #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign rdata     = mem_q[rd_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_q <= wr_q + AW'(1);
      if (do_pop_s)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push_s && !rst && !flush) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/decoder_strobe.sv
// Sequential 3-to-8 decoder: queues codes and replays each as a one-hot
// strobe held for HOLD cycles followed by GAP idle cycles.
module decoder_strobe
  import decoder_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int HOLD  = 2,
  parameter  int GAP   = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Flush,
  input  logic [CODE_W-1:0] Code,
  input  logic              CodeValid,
  output logic              CodeReady,
  output logic [OUT_W-1:0]  Data,
  output logic              DataValid,
  output logic [CNT_W-1:0]  Count,
  output logic              Busy
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_e            state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              dv_q, dv_d;
  logic              pop_s;
  logic              push_s;
  logic              full_s;
  logic              empty_s;
  logic [CODE_W-1:0] head_s;

  // A full FIFO refuses input even when it pops in the same cycle.
  assign CodeReady = !rst && !Flush && !full_s;
  assign push_s    = CodeValid && CodeReady;
  assign Data      = data_q;
  assign DataValid = dv_q;
  assign Busy      = (state_q != ST_IDLE) || !empty_s;

  code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (Flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (Code),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (Count)
  );

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    data_d  = data_q;
    dv_d    = dv_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          data_d  = decode_onehot(head_s);
          dv_d    = 1'b1;
          hcnt_d  = HW'(HOLD - 1);
          state_d = ST_HOLD;
        end else begin
          data_d = {OUT_W{1'b0}};
          dv_d   = 1'b0;
        end
      end
      ST_HOLD: begin
        if (hcnt_q == {HW{1'b0}}) begin
          data_d  = {OUT_W{1'b0}};
          dv_d    = 1'b0;
          gcnt_d  = GW'(GAP - 1);
          state_d = ST_GAP;
        end else begin
          hcnt_d = hcnt_q - HW'(1);
        end
      end
      ST_GAP: begin
        if (gcnt_q == {GW{1'b0}}) begin
          // Back-to-back strobes: the next code loads straight out of GAP.
          if (!empty_s) begin
            pop_s   = 1'b1;
            data_d  = decode_onehot(head_s);
            dv_d    = 1'b1;
            hcnt_d  = HW'(HOLD - 1);
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: begin
        data_d  = {OUT_W{1'b0}};
        dv_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      state_q <= ST_IDLE;
      hcnt_q  <= {HW{1'b0}};
      gcnt_q  <= {GW{1'b0}};
      data_q  <= {OUT_W{1'b0}};
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      gcnt_q  <= gcnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
    end
  end

endmodule

// File: tb/tb_decoder_strobe.sv
// Scoreboard bench for decoder_strobe: stimulus pushes accepted codes, a monitor
// predicts strobe timing from the hold/gap rules and compares every cycle.
module tb_decoder_strobe;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int GAP   = 1;
  localparam int BIG   = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       Flush;
  logic [2:0] Code;
  logic       CodeValid;
  logic       CodeReady;
  logic [7:0] Data;
  logic       DataValid;
  logic [2:0] Count;
  logic       Busy;

  int         checks = 0;
  int         errors = 0;
  int         tmo_cnt = 0;
  logic [2:0] exp_q[$];
  logic       armed = 1'b0;
  logic       done = 1'b0;
  logic       clr_edge = 1'b0;
  logic       rdy_exp_s = 1'b0;
  logic       rdy_act_s = 1'b0;

  logic       dv_prev = 1'b0;
  int         sz_prev = 0;
  int         age = BIG;
  logic [2:0] cur = 3'd0;
  logic       exp_start;
  logic       dut_start;
  logic [7:0] one;
  logic [7:0] exp_data;

  always #5 clk = ~clk;

  decoder_strobe #(
    .DEPTH (DEPTH),
    .HOLD  (HOLD),
    .GAP   (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Flush     (Flush),
    .Code      (Code),
    .CodeValid (CodeValid),
    .CodeReady (CodeReady),
    .Data      (Data),
    .DataValid (DataValid),
    .Count     (Count),
    .Busy      (Busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // One cycle of stimulus: drive mid-cycle, predict readiness, record acceptance.
  task automatic cyc(input logic v, input logic [2:0] c, input logic f, input logic r);
    @(negedge clk);
    CodeValid = v;
    Code      = c;
    Flush     = f;
    rst       = r;
    #1;
    rdy_exp_s = !r && !f && (exp_q.size() < DEPTH);
    rdy_act_s = CodeReady;
    clr_edge  = r || f;
    if (v && rdy_exp_s) exp_q.push_back(c);
    armed = 1'b1;
  endtask

  task automatic send(input logic [2:0] c);
    for (int i = 0; i < 50; i++) begin
      cyc(1'b1, c, 1'b0, 1'b0);
      if (rdy_exp_s) return;
    end
    tmo_cnt++;
    $display("FAIL send_timeout code=%0d", c);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 3'd0, 1'b0, 1'b0);
      if (!Busy && exp_q.size() == 0) return;
    end
    tmo_cnt++;
    $display("FAIL drain_timeout busy=%0d pending=%0d", Busy, exp_q.size());
  endtask

  task automatic wait_data(input logic [7:0] d);
    int i;
    i = 0;
    while (Data != d && i < 60) begin
      cyc(1'b0, 3'd0, 1'b0, 1'b0);
      i++;
    end
    if (Data != d) begin
      tmo_cnt++;
      $display("FAIL wait_data_timeout got %0h expected %0h", Data, d);
    end
  endtask

  // Stimulus
  initial begin
    rst       = 1'b1;
    Flush     = 1'b0;
    CodeValid = 1'b0;
    Code      = 3'd0;
    repeat (3) cyc(1'b1, 3'd2, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 1'b0, 1'b0);

    cyc(1'b1, 3'd5, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 3'd0, 1'b0, 1'b0);

    for (int c = 0; c < 8; c++) send(3'(c));
    drain();

    send(3'd6); send(3'd3); send(3'd1); send(3'd2); send(3'd4);
    wait_data(8'h08);
    cyc(1'b1, 3'd7, 1'b1, 1'b0);
    repeat (6) cyc(1'b0, 3'd0, 1'b0, 1'b0);

    send(3'd5); send(3'd6); send(3'd7);
    wait_data(8'h20);
    repeat (HOLD - 1) cyc(1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 1'b0, 1'b1);
    repeat (6) cyc(1'b0, 3'd0, 1'b0, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), r < 3, r >= 98);
    end
    drain();
    done = 1'b1;
  end

  // Monitor and scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        chk("code_ready", 32'(rdy_act_s), 32'(rdy_exp_s));
        dut_start = DataValid && !dv_prev;
        if (clr_edge) begin
          exp_q.delete();
          age       = BIG;
          exp_start = 1'b0;
        end else begin
          exp_start = (sz_prev > 0) && (age >= HOLD + GAP - 1);
        end
        chk("strobe_start", 32'(dut_start), 32'(exp_start));
        if (exp_start) begin
          cur = exp_q.pop_front();
          age = 0;
        end else if (age < BIG) begin
          age++;
        end
        one      = 8'h01;
        exp_data = (age < HOLD) ? (one << cur) : 8'h00;
        chk("data", 32'(Data), 32'(exp_data));
        chk("data_valid", 32'(DataValid), 32'(age < HOLD));
        chk("count", 32'(Count), 32'(exp_q.size()));
        chk("busy", 32'(Busy), 32'((exp_q.size() != 0) || (age < HOLD + GAP)));
        dv_prev = DataValid;
        sz_prev = exp_q.size();
        if (done) begin
          chk("timeouts", 32'(tmo_cnt), 32'd0);
          chk("drained", 32'(exp_q.size()), 32'd0);
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $finish;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
